// File: rtl/dcw_sampler_dwa.sv
// DTC control-word sampler: splits the loop DCW into unary MSB cells and binary LSBs on refdtc falling edges.
// Optional data-weighted-averaging rotation of the unary cells is enabled by defining DCWSMP_DWA_EN.
module dcw_sampler_dwa #(
  parameter  int unsigned DTC_L = 12,
  parameter  int unsigned TH_B  = 3,
  localparam int unsigned M     = (1 << TH_B) - 1,
  localparam int unsigned BW    = DTC_L - TH_B
) (
  input  logic             refdtc,
  input  logic             sync_nrst,
  input  logic [DTC_L-1:0] dcw_in,
  input  logic             hold,
  output logic [M-1:0]     loop_temp_code,
  output logic [BW-1:0]    loop_binary_out,
  output logic [DTC_L-1:0] dcw_out,
  output logic [TH_B-1:0]  dwa_ptr,
  output logic             out_vld
);

  localparam logic [TH_B:0] M_W = (TH_B+1)'(M);

  logic [TH_B-1:0]  n_c;
  logic [M-1:0]     code_d, code_q;
  logic [BW-1:0]    bin_q;
  logic [DTC_L-1:0] dcw_q;
  logic             vld_q;

  assign n_c = dcw_in[DTC_L-1 -: TH_B];

`ifdef DCWSMP_DWA_EN
  logic [TH_B-1:0] ptr_d, ptr_q;
  logic [TH_B:0]   off;
  logic [TH_B:0]   sum;

  // Cell i is enabled when its distance from the pointer (mod M) is below N.
  always_comb begin
    code_d = '0;
    off    = '0;
    for (int i = 0; i < int'(M); i++) begin
      off = (TH_B+1)'(i) + M_W - {1'b0, ptr_q};
      if (off >= M_W) off = off - M_W;
      code_d[i] = (off < {1'b0, n_c});
    end
    sum   = {1'b0, ptr_q} + {1'b0, n_c};
    ptr_d = (sum >= M_W) ? TH_B'(sum - M_W) : TH_B'(sum);
  end

  always_ff @(negedge refdtc or negedge sync_nrst) begin
    if (!sync_nrst) begin
      ptr_q <= '0;
    end else if (!hold) begin
      ptr_q <= ptr_d;
    end
  end

  assign dwa_ptr = ptr_q;
`else
  // Plain thermometer: low N cells enabled.
  always_comb begin
    code_d = '0;
    for (int i = 0; i < int'(M); i++) begin
      code_d[i] = ((TH_B+1)'(i) < {1'b0, n_c});
    end
  end

  assign dwa_ptr = '0;
`endif

  // Output registers, frozen while hold is high.
  always_ff @(negedge refdtc or negedge sync_nrst) begin
    if (!sync_nrst) begin
      code_q <= '0;
      bin_q  <= '0;
      dcw_q  <= '0;
      vld_q  <= 1'b0;
    end else if (!hold) begin
      code_q <= code_d;
      bin_q  <= dcw_in[BW-1:0];
      dcw_q  <= dcw_in;
      vld_q  <= 1'b1;
    end
  end

  assign loop_temp_code  = code_q;
  assign loop_binary_out = bin_q;
  assign dcw_out         = dcw_q;
  assign out_vld         = vld_q;

endmodule

// File: tb/tb_dcw_sampler_dwa.sv
// Self-checking bench for dcw_sampler_dwa (DTC_L=12, TH_B=3); works with or without DCWSMP_DWA_EN.
module tb_dcw_sampler_dwa;

  localparam int DTC_L = 12;
  localparam int TH_B  = 3;
  localparam int M     = 7;
  localparam int BW    = DTC_L - TH_B;

  logic             refdtc;
  logic             sync_nrst;
  logic [DTC_L-1:0] dcw_in;
  logic             hold;
  logic [M-1:0]     loop_temp_code;
  logic [BW-1:0]    loop_binary_out;
  logic [DTC_L-1:0] dcw_out;
  logic [TH_B-1:0]  dwa_ptr;
  logic             out_vld;

  int total = 0;
  int bad   = 0;

  dcw_sampler_dwa #(.DTC_L(DTC_L), .TH_B(TH_B)) dut (
    .refdtc          (refdtc),
    .sync_nrst       (sync_nrst),
    .dcw_in          (dcw_in),
    .hold            (hold),
    .loop_temp_code  (loop_temp_code),
    .loop_binary_out (loop_binary_out),
    .dcw_out         (dcw_out),
    .dwa_ptr         (dwa_ptr),
    .out_vld         (out_vld)
  );

  initial refdtc = 1'b0;
  always #5 refdtc = ~refdtc;

  // Reference model: integer pointer, cells filled one by one with wrap.
  int m_ptr  = 0;
  int m_code = 0;
  int m_bin  = 0;
  int m_dcw  = 0;
  int m_vld  = 0;

  always @(negedge refdtc or negedge sync_nrst) begin
    if (!sync_nrst) begin
      m_ptr = 0; m_code = 0; m_bin = 0; m_dcw = 0; m_vld = 0;
    end else if (!hold) begin
      int n;
      n      = int'(dcw_in) / (1 << BW);
      m_code = 0;
`ifdef DCWSMP_DWA_EN
      for (int k = 0; k < n; k++) m_code = m_code | (1 << ((m_ptr + k) % M));
      m_ptr = (m_ptr + n) % M;
`else
      m_code = (1 << n) - 1;
`endif
      m_bin = int'(dcw_in) % (1 << BW);
      m_dcw = int'(dcw_in);
      m_vld = 1;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the falling edge.
  always @(posedge refdtc) begin
    #1;
    chk("model_code", int'(loop_temp_code), m_code);
    chk("model_bin",  int'(loop_binary_out), m_bin);
    chk("model_dcw",  int'(dcw_out), m_dcw);
    chk("model_ptr",  int'(dwa_ptr), m_ptr);
    chk("model_vld",  int'(out_vld), m_vld);
  end

  // One sample: drive after the rising edge, return just after the falling edge.
  task automatic step(input logic [DTC_L-1:0] d, input logic h);
    @(posedge refdtc);
    #2;
    dcw_in = d;
    hold   = h;
    @(negedge refdtc);
    #2;
  endtask

  task automatic chk_all(input string name, input int code, input int bin,
                         input int dcw, input int ptr, input int vld);
    chk({name, "_code"}, int'(loop_temp_code), code);
    chk({name, "_bin"},  int'(loop_binary_out), bin);
    chk({name, "_dcw"},  int'(dcw_out), dcw);
    chk({name, "_ptr"},  int'(dwa_ptr), ptr);
    chk({name, "_vld"},  int'(out_vld), vld);
  endtask

  task automatic do_reset();
    @(posedge refdtc);
    #2;
    sync_nrst = 1'b0;
    hold      = 1'b0;
    repeat (3) @(negedge refdtc);
    #2;
    sync_nrst = 1'b1;
  endtask

  initial begin
    sync_nrst = 1'b0;
    hold      = 1'b0;
    dcw_in    = 12'h3C3;
    repeat (3) @(negedge refdtc);
    #2;
    chk_all("reset", 0, 0, 0, 0, 0);
    sync_nrst = 1'b1;

    step(12'hA05, 1'b0);
`ifdef DCWSMP_DWA_EN
    chk_all("first", 7'b0011111, 9'h005, 12'hA05, 5, 1);
`else
    chk_all("first", 7'b0011111, 9'h005, 12'hA05, 0, 1);
`endif
    step(12'h000, 1'b0);
    chk("zero_code", int'(loop_temp_code), 7'b0000000);
    step(12'hFFF, 1'b0);
    chk("full_code", int'(loop_temp_code), 7'b1111111);
    chk("full_bin",  int'(loop_binary_out), 9'h1FF);

    // Rotation sequence N = 5, 3, 7, 0 from reset.
    do_reset();
    step(12'hA00, 1'b0);
`ifdef DCWSMP_DWA_EN
    chk("rot5_code", int'(loop_temp_code), 7'b0011111); chk("rot5_ptr", int'(dwa_ptr), 5);
    step(12'h600, 1'b0);
    chk("rot3_code", int'(loop_temp_code), 7'b1100001); chk("rot3_ptr", int'(dwa_ptr), 1);
    step(12'hE00, 1'b0);
    chk("rot7_code", int'(loop_temp_code), 7'b1111111); chk("rot7_ptr", int'(dwa_ptr), 1);
    step(12'h000, 1'b0);
    chk("rot0_code", int'(loop_temp_code), 7'b0000000); chk("rot0_ptr", int'(dwa_ptr), 1);
`else
    chk("rot5_code", int'(loop_temp_code), 7'b0011111); chk("rot5_ptr", int'(dwa_ptr), 0);
    step(12'h600, 1'b0);
    chk("rot3_code", int'(loop_temp_code), 7'b0000111); chk("rot3_ptr", int'(dwa_ptr), 0);
    step(12'hE00, 1'b0);
    chk("rot7_code", int'(loop_temp_code), 7'b1111111); chk("rot7_ptr", int'(dwa_ptr), 0);
    step(12'h000, 1'b0);
    chk("rot0_code", int'(loop_temp_code), 7'b0000000); chk("rot0_ptr", int'(dwa_ptr), 0);
`endif

    // Hold: sample 600, freeze for three edges with 1FF applied, then release.
    step(12'h600, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(12'h1FF, 1'b1);
`ifdef DCWSMP_DWA_EN
      chk_all("hold", 7'b0001110, 9'h000, 12'h600, 4, 1);
`else
      chk_all("hold", 7'b0000111, 9'h000, 12'h600, 0, 1);
`endif
    end
    step(12'h1FF, 1'b0);
    chk("rel_code", int'(loop_temp_code), 7'b0000000);
    chk("rel_bin",  int'(loop_binary_out), 9'h1FF);
    chk("rel_dcw",  int'(dcw_out), 12'h1FF);

    // Asynchronous reset between edges while frozen.
    step(12'hA05, 1'b1);
    @(posedge refdtc);
    #2;
    sync_nrst = 1'b0;
    #1;
    chk_all("async_rst", 0, 0, 0, 0, 0);
    @(negedge refdtc);
    #2;
    sync_nrst = 1'b1;
    step(12'hA05, 1'b0);
`ifdef DCWSMP_DWA_EN
    chk_all("restart", 7'b0011111, 9'h005, 12'hA05, 5, 1);
`else
    chk_all("restart", 7'b0011111, 9'h005, 12'hA05, 0, 1);
`endif

    repeat (2) @(posedge refdtc);
    #3;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dcw_sampler_dwa.md
Name: dcw_sampler_dwa

Overview:
Parametrised DTC control-word sampler. It captures the loop DCW on the falling edge of the DTC reference clock and splits it into a unary (thermometer) MSB segment and a binary LSB segment for the DTC array. It sits between the digital loop filter/DCW generator and the DTC analog macro. It adds a freeze (hold) input, an output-valid flag, and optional data-weighted-averaging (DWA) rotation of the unary cells to spread mismatch.

Parameters:
DTC_L, 12, total DCW width in bits.
TH_B, 3, number of DCW MSBs decoded to unary; unary cell count M = 2^TH_B - 1. Legal range 1..DTC_L-1.

Ports:
refdtc  input  1  DTC reference clock; all state updates on its falling edge.
sync_nrst  input  1  reset, asynchronous, active-low (already synchronised upstream).
dcw_in  input  DTC_L  loop DCW, stable around the refdtc falling edge.
hold  input  1  freeze: 1 = keep all registered outputs and internal state.
loop_temp_code  output  M  unary cell enables; bit i drives unary cell i.
loop_binary_out  output  DTC_L-TH_B  binary LSB segment, equal to dcw_in[DTC_L-TH_B-1:0].
dcw_out  output  DTC_L  registered copy of the sampled dcw_in (test observation).
dwa_ptr  output  TH_B  current DWA start pointer (always 0 when DWA is compiled out).
out_vld  output  1  high from the first non-held sample after reset.

Behaviour:
- Reset (sync_nrst=0, asynchronous): loop_temp_code=0, loop_binary_out=0, dcw_out=0, dwa_ptr=0, out_vld=0. Release takes effect at the next refdtc falling edge.
- Sampling: on each refdtc falling edge with hold=0, all outputs update from dcw_in. Latency is 1 falling edge; there is no combinational path from input to output.
- Let N = dcw_in[DTC_L-1:DTC_L-TH_B], with 0 <= N <= M.
- Unary decode (non-DWA): loop_temp_code = (1<<N)-1, i.e. the low N bits set. N=0 gives all zeros; N=M gives all ones.
- loop_binary_out <= dcw_in[DTC_L-TH_B-1:0]; dcw_out <= dcw_in.
- out_vld is set to 1 on the first falling edge with hold=0 and stays 1 until reset.
- hold=1: every output register and dwa_ptr keep their values; out_vld does not change.
- Reset asserted mid-operation clears all state immediately, regardless of hold.
- Width rules: all pointer arithmetic is modulo M, not modulo 2^TH_B. dwa_ptr never takes the value M.

Optional Feature:
Macro DCWSMP_DWA_EN.
- Defined:
  - loop_temp_code sets N consecutive bits starting at index dwa_ptr, wrapping from M-1 to 0.
  - dwa_ptr <= (dwa_ptr + N) mod M, updated on the same edge.
  - N=0: all zeros, pointer unchanged.
  - N=M: all ones, pointer unchanged.
  - hold=1 freezes the pointer.
- Not defined:
  - Plain unary decode as above.
  - dwa_ptr is tied to 0 and no rotation logic is synthesised.
- loop_binary_out, dcw_out and out_vld are identical in both builds.

Test Plan:
(All scenarios use DTC_L=12, TH_B=3, M=7.)
- Reset then idle: hold sync_nrst=0 and toggle refdtc -> all outputs 0, out_vld=0. Release, then drive dcw_in=12'hA05 for one falling edge -> out_vld=1, dcw_out=12'hA05, loop_binary_out=9'h005, loop_temp_code=7'b0011111 (non-DWA build).
- Endpoints, non-DWA: dcw_in=12'h000 -> loop_temp_code=7'b0000000. dcw_in=12'hFFF -> loop_temp_code=7'b1111111, loop_binary_out=9'h1FF.
- DWA rotation (DCWSMP_DWA_EN defined): from reset, apply N=5 then N=3 then N=7 then N=0:
  - N=5 -> 7'b0011111, ptr=5.
  - N=3 -> 7'b1100001, ptr=1.
  - N=7 -> 7'b1111111, ptr=1.
  - N=0 -> 7'b0000000, ptr=1.
- Hold: after dcw_in=12'h600 is sampled, set hold=1 and change dcw_in to 12'h1FF for 3 edges -> outputs and dwa_ptr unchanged. Release hold -> next edge shows loop_binary_out=9'h1FF and loop_temp_code=7'b0000000.
- Reset mid-stream: assert sync_nrst between refdtc edges while hold=1 and ptr=4 -> all outputs and ptr clear immediately. After release, the first sample restarts rotation at index 0.
